// File: rtl/frame_pixel_packer.sv
// frame_pixel_packer: packs a byte stream into pixels and issues addressed frame-memory writes
module frame_pixel_packer #(
  parameter int BYTES_PER_PX = 3,
  parameter int H_ACTIVE = 110,
  parameter int V_ACTIVE = 110,
  parameter int ADDR_W = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic [7:0] byte_in,
  input  logic byte_valid,
  input  logic byte_sof,
  output logic byte_ready,
  output logic [8*BYTES_PER_PX-1:0] px_data,
  output logic [9:0] px_col,
  output logic [9:0] px_line,
  output logic [ADDR_W-1:0] px_addr,
  output logic px_we,
  input  logic wr_ready,
  output logic frame_done,
  output logic err_sof
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [1:0] idx, k;
  logic [9:0] col, line, ncol, pcol, pline;
  logic [8*BYTES_PER_PX-1:0] buf_q, asm_px;
  logic take, hs, start, use_b, done_px, last, wrap;
  assign byte_ready = !reset && (state == IDLE || !(px_we && !wr_ready));
  always_comb begin
    take = byte_valid && byte_ready;
    hs = px_we && wr_ready;
    start = take && byte_sof;
    use_b = take && (byte_sof || state == ACTIVE);
    k = start ? 2'd0 : idx;
    done_px = use_b && k == 2'(BYTES_PER_PX - 1);
    last = hs && line == 10'(V_ACTIVE - 1) && col == 10'(H_ACTIVE - 1);
    wrap = last && !start;
    ncol = col == 10'(H_ACTIVE - 1) ? 10'd0 : col + 10'd1;
    pcol = start ? 10'd0 : hs ? ncol : col;
    pline = (start || last) ? 10'd0 : (hs && ncol == 10'd0) ? line + 10'd1 : line;
    asm_px = buf_q;
    asm_px[8*(BYTES_PER_PX-1-int'(k)) +: 8] = byte_in;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= 2'd0;
      col <= 10'd0;
      line <= 10'd0;
      buf_q <= '0;
      px_data <= '0;
      px_col <= 10'd0;
      px_line <= 10'd0;
      px_addr <= '0;
      px_we <= 1'b0;
      frame_done <= 1'b0;
      err_sof <= 1'b0;
    end else begin
      frame_done <= last;
      err_sof <= start && state == ACTIVE && (idx != 2'd0 || col != 10'd0 || line != 10'd0);
      state <= start ? ACTIVE : wrap ? IDLE : state;
      idx <= wrap ? 2'd0 : use_b ? (done_px ? 2'd0 : k + 2'd1) : idx;
      col <= pcol;
      line <= pline;
      px_we <= (done_px && !wrap) ? 1'b1 : hs ? 1'b0 : px_we;
      if (use_b) buf_q <= asm_px;
      if (done_px && !wrap) begin
        px_data <= asm_px;
        px_col <= pcol;
        px_line <= pline;
        px_addr <= ADDR_W'(int'(pline) * H_ACTIVE + int'(pcol));
      end
    end
  end
endmodule

// File: tb/tb_frame_pixel_packer.sv
// tb_frame_pixel_packer: self-checking bench for frame_pixel_packer
module tb_frame_pixel_packer;
  localparam int BPP = 3;
  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 4;
  typedef struct {logic sof; logic [7:0] d;} ent_t;
  typedef struct {logic [23:0] d; int a;} wr_t;
  logic clk = 0;
  logic reset = 1;
  logic [7:0] byte_in = 0;
  logic byte_valid = 0;
  logic byte_sof = 0;
  logic wr_ready = 1;
  logic byte_ready, px_we, frame_done, err_sof;
  logic [8*BPP-1:0] px_data;
  logic [9:0] px_col, px_line;
  logic [AW-1:0] px_addr;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  frame_pixel_packer #(.BYTES_PER_PX(BPP), .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid), .byte_sof(byte_sof),
    .byte_ready(byte_ready), .px_data(px_data), .px_col(px_col), .px_line(px_line),
    .px_addr(px_addr), .px_we(px_we), .wr_ready(wr_ready), .frame_done(frame_done), .err_sof(err_sof)
  );
  task automatic do_reset;
    reset = 1;
    byte_valid = 0;
    byte_sof = 0;
    wr_ready = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask
  task automatic test_reset;
    reset = 1;
    byte_valid = 1;
    byte_sof = 1;
    byte_in = 8'h77;
    repeat (2) @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", byte_ready); end
    checks++;
    if ({px_we, frame_done, err_sof, px_data, px_col, px_line, px_addr} !== '0) begin
      errors++; $display("FAIL reset_outputs got we=%b fd=%b es=%b d=%h c=%0d l=%0d a=%0d want all 0", px_we, frame_done, err_sof, px_data, px_col, px_line, px_addr);
    end
    byte_valid = 0;
    byte_sof = 0;
    reset = 0;
    #1;
    checks++;
    if (byte_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", byte_ready); end
    @(negedge clk);
  endtask
  task automatic test_basic;
    do_reset;
    byte_valid = 1;
    byte_sof = 1;
    byte_in = 8'h12;
    @(negedge clk);
    byte_sof = 0;
    byte_in = 8'h34;
    @(negedge clk);
    byte_in = 8'h56;
    @(negedge clk);
    byte_valid = 0;
    checks++;
    if (px_we !== 1'b1) begin errors++; $display("FAIL basic_we got %b want 1", px_we); end
    checks++;
    if (px_data !== 24'h123456) begin errors++; $display("FAIL basic_data got %h want 123456", px_data); end
    checks++;
    if ({px_addr, px_col, px_line} !== '0) begin errors++; $display("FAIL basic_pos got a=%0d c=%0d l=%0d want 0", px_addr, px_col, px_line); end
    @(negedge clk);
    checks++;
    if (px_we !== 1'b0) begin errors++; $display("FAIL basic_we_clear got %b want 0", px_we); end
  endtask
  task automatic test_frame;
    int writes, dones, idle_we;
    logic prev7;
    writes = 0;
    dones = 0;
    idle_we = 0;
    prev7 = 0;
    do_reset;
    for (int c = 0; c < 30; c++) begin
      byte_valid = c < 24;
      byte_sof = c == 0;
      byte_in = 8'(c);
      @(negedge clk);
      if (px_we) begin
        checks++;
        if (px_addr !== AW'(writes) || px_col !== 10'(writes % H) || px_line !== 10'(writes / H) ||
            px_data !== {8'(3*writes), 8'(3*writes+1), 8'(3*writes+2)}) begin
          errors++; $display("FAIL frame_write got a=%0d c=%0d l=%0d d=%h want a=%0d", px_addr, px_col, px_line, px_data, writes);
        end
        writes++;
      end
      if (frame_done) begin
        dones++;
        checks++;
        if (!prev7) begin errors++; $display("FAIL frame_done_timing got pulse at cycle %0d want after addr 7", c); end
      end
      prev7 = px_we && px_addr == AW'(7);
    end
    checks++;
    if (writes !== 8) begin errors++; $display("FAIL frame_writes got %0d want 8", writes); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL frame_dones got %0d want 1", dones); end
    for (int c = 0; c < 8; c++) begin
      byte_valid = c < 3;
      byte_sof = 0;
      byte_in = 8'hC0;
      @(negedge clk);
      if (px_we) idle_we++;
    end
    checks++;
    if (idle_we !== 0) begin errors++; $display("FAIL idle_writes got %0d want 0", idle_we); end
  endtask
  task automatic test_stall;
    int ptr, stall, writes;
    logic stalled;
    ptr = 0;
    stall = 0;
    writes = 0;
    stalled = 0;
    do_reset;
    for (int c = 0; c < 40; c++) begin
      if (!stalled && px_we && px_addr == AW'(1)) begin stalled = 1; stall = 5; end
      wr_ready = stall == 0;
      if (stall > 0) begin
        checks++;
        if (px_we !== 1'b1 || px_addr !== AW'(1)) begin errors++; $display("FAIL stall_hold got we=%b a=%0d want we=1 a=1", px_we, px_addr); end
      end
      byte_valid = ptr < 9;
      byte_sof = ptr == 0;
      byte_in = 8'(160 + ptr);
      #1;
      if (stall > 0) begin
        checks++;
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", byte_ready); end
        stall--;
      end
      if (byte_valid && byte_ready) ptr++;
      if (px_we && wr_ready) begin
        checks++;
        if (px_addr !== AW'(writes) || px_data !== {8'(160+3*writes), 8'(161+3*writes), 8'(162+3*writes)}) begin
          errors++; $display("FAIL stall_write got a=%0d d=%h want a=%0d", px_addr, px_data, writes);
        end
        writes++;
      end
      @(negedge clk);
    end
    byte_valid = 0;
    wr_ready = 1;
    checks++;
    if (writes !== 3 || ptr !== 9 || !stalled) begin errors++; $display("FAIL stall_total got writes=%0d bytes=%0d want 3 9", writes, ptr); end
  endtask
  task automatic test_sof_err;
    logic [23:0] exp_d[3];
    int exp_a[3];
    int writes, errs;
    exp_d = '{24'h101112, 24'h131415, 24'hE0E1E2};
    exp_a = '{0, 1, 0};
    writes = 0;
    errs = 0;
    do_reset;
    for (int c = 0; c < 18; c++) begin
      byte_valid = c < 11;
      byte_sof = c == 0 || c == 8;
      byte_in = c < 8 ? 8'(16 + c) : 8'(224 + c - 8);
      @(negedge clk);
      if (px_we) begin
        checks++;
        if (writes >= 3 || px_data !== exp_d[writes] || px_addr !== AW'(exp_a[writes])) begin
          errors++; $display("FAIL sof_err_write got a=%0d d=%h (write %0d)", px_addr, px_data, writes);
        end
        writes++;
      end
      if (err_sof) begin
        errs++;
        checks++;
        if (c !== 8) begin errors++; $display("FAIL err_sof_timing got cycle %0d want 8", c); end
      end
    end
    checks++;
    if (writes !== 3 || errs !== 1) begin errors++; $display("FAIL sof_err_total got writes=%0d errs=%0d want 3 1", writes, errs); end
  endtask
  task automatic test_reset_mid;
    int we_cnt;
    we_cnt = 0;
    do_reset;
    wr_ready = 0;
    byte_valid = 1;
    byte_sof = 1;
    byte_in = 8'hAA;
    @(negedge clk);
    byte_sof = 0;
    byte_in = 8'hBB;
    @(negedge clk);
    byte_in = 8'hCC;
    @(negedge clk);
    byte_valid = 0;
    @(negedge clk);
    checks++;
    if (px_we !== 1'b1 || px_data !== 24'hAABBCC) begin errors++; $display("FAIL mid_pending got we=%b d=%h want 1 aabbcc", px_we, px_data); end
    reset = 1;
    @(negedge clk);
    checks++;
    if ({px_we, frame_done, err_sof, px_data, px_col, px_line, px_addr, byte_ready} !== '0) begin
      errors++; $display("FAIL mid_reset got we=%b d=%h a=%0d rdy=%b want all 0", px_we, px_data, px_addr, byte_ready);
    end
    reset = 0;
    wr_ready = 1;
    for (int c = 0; c < 8; c++) begin
      byte_valid = c < 3;
      byte_sof = 0;
      byte_in = 8'(c);
      @(negedge clk);
      if (px_we) we_cnt++;
    end
    checks++;
    if (we_cnt !== 0) begin errors++; $display("FAIL mid_nosof_writes got %0d want 0", we_cnt); end
  endtask
  task automatic test_random;
    ent_t plan[$];
    ent_t ent;
    wr_t exp_q[$];
    wr_t e;
    logic [7:0] part[$];
    logic in_frame;
    int cnt, started, dones, errs, cyc;
    in_frame = 0;
    cnt = 0;
    started = 0;
    dones = 0;
    errs = 0;
    cyc = 0;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < H * V * BPP; i++) begin
        ent.sof = i == 0;
        ent.d = 8'($urandom);
        plan.push_back(ent);
      end
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        ent.sof = 0;
        ent.d = 8'($urandom);
        plan.push_back(ent);
      end
    end
    do_reset;
    while (cyc < 5000 && !(plan.size() == 0 && dones == 4 && exp_q.size() == 0)) begin
      wr_ready = $urandom_range(0, 3) != 0;
      if (plan.size() > 0 && !(plan[0].sof && dones < started)) begin
        byte_valid = $urandom_range(0, 3) != 0;
        byte_sof = plan[0].sof;
        byte_in = plan[0].d;
      end else begin
        byte_valid = 0;
        byte_sof = 0;
      end
      #1;
      if (byte_valid && byte_ready) begin
        ent = plan.pop_front();
        if (ent.sof) begin started++; in_frame = 1; part.delete(); cnt = 0; end
        if (in_frame) begin
          part.push_back(ent.d);
          if (part.size() == BPP) begin
            e.d = {part[0], part[1], part[2]};
            e.a = cnt;
            exp_q.push_back(e);
            part.delete();
            cnt++;
            if (cnt == H * V) in_frame = 0;
          end
        end
      end
      if (px_we && wr_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra_write got a=%0d d=%h want none", px_addr, px_data);
        end else begin
          e = exp_q.pop_front();
          if (px_data !== e.d || px_addr !== AW'(e.a) || px_col !== 10'(e.a % H) || px_line !== 10'(e.a / H)) begin
            errors++; $display("FAIL rand_write got a=%0d c=%0d l=%0d d=%h want a=%0d d=%h", px_addr, px_col, px_line, px_data, e.a, e.d);
          end
        end
      end
      @(negedge clk);
      if (frame_done) dones++;
      if (err_sof) errs++;
      cyc++;
    end
    byte_valid = 0;
    wr_ready = 1;
    checks++;
    if (cyc >= 5000) begin errors++; $display("FAIL rand_timeout got %0d cycles want < 5000", cyc); end
    checks++;
    if (dones !== 4 || errs !== 0 || exp_q.size() !== 0) begin
      errors++; $display("FAIL rand_totals got dones=%0d errs=%0d pending=%0d want 4 0 0", dones, errs, exp_q.size());
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_frame;
    test_stall;
    test_sof_err;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
